core_lsu: RTL
=============

Name: core_lsu

Overview:
- Parametrised load/store unit; successor to the single-cycle MEM-stage data path.
- Sits between EX/MEM pipeline registers and an external data bus with a valid/ready request channel and a valid response channel.
- Supports multi-cycle bus latency, byte/half/word/double access sizes, and sign/zero extension.
- Flags misaligned and illegal accesses.
- Drives a stall to the pipeline while a transaction is outstanding.

Parameters:
- DATA_W, 64, bus/register data width; legal values 32 or 64.
- ADDR_W, 64, address width.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with CORE_LSU_TIMEOUT_EN.

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  pipeline request present
- req_ready  out  1  LSU can accept a request
- req_store  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=double
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- req_regnum  in  5  destination register
- stall  out  1  pipeline must hold
- d_req_valid  out  1  bus request
- d_req_ready  in  1  bus accepts request
- d_we  out  1  bus write
- d_addr  out  ADDR_W  lane-aligned address
- d_wdata  out  DATA_W  lane-positioned store data
- d_wstrb  out  DATA_W/8  byte strobes
- d_rsp_valid  in  1  bus response/ack
- d_rdata  in  DATA_W  bus read data
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  DATA_W  extended load data; 0 for stores and errors
- resp_regnum  out  5  latched req_regnum
- misaligned  out  1  qualified by resp_valid
- bus_err  out  1  qualified by resp_valid

Behaviour:
- Reset: all outputs 0 except req_ready=1. State goes to IDLE. Reset mid-transaction abandons it; a late d_rsp_valid after reset is ignored in IDLE.
- States: IDLE, REQ, WAIT, RESP. All outputs are registered or decoded from state plus latched fields.
- IDLE:
  - req_ready=1, stall=0.
  - On req_valid, latch all req_* fields.
  - Misaligned access (addr mod 2^size != 0), or size=3 with DATA_W=32: go to RESP with misaligned=1. No bus activity.
  - Otherwise go to REQ.
- REQ:
  - d_req_valid=1.
  - d_addr = addr with the low log2(DATA_W/8) bits cleared.
  - d_wstrb = (2^(2^size))-1 shifted left by the lane offset; all ones for loads.
  - d_wdata = wdata shifted left by 8×offset.
  - d_we = store.
  - Hold all bus outputs stable until d_req_ready=1, then go to WAIT.
  - d_rsp_valid in REQ is ignored; the bus must respond no earlier than the cycle after the handshake.
- WAIT:
  - On d_rsp_valid, go to RESP.
  - For loads, capture d_rdata shifted right by 8×offset, masked to the access size, then sign- or zero-extended per req_signed.
- RESP:
  - resp_valid=1 for exactly one cycle, with resp_regnum, then go to IDLE.
- stall=1 in REQ, WAIT and RESP. stall=1 in IDLE when req_valid is accepted, so the request cycle itself holds the pipe.
- Minimum latency: request accepted at cycle N. With d_req_ready=1 and a single-cycle response, resp_valid is asserted at N+3.
- Back-to-back requests: a new request is accepted only in IDLE, one cycle after RESP.

Optional Feature:
- CORE_LSU_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When the count reaches TIMEOUT_CYCLES, go to RESP with bus_err=1 and resp_data=0, and deassert d_req_valid.
  - A late d_rsp_valid is then ignored.
- Not defined: bus_err is tied 0, no counter exists, and the LSU waits indefinitely.

Test Plan:
- Signed byte load, DATA_W=64, addr=0x1003. Bus returns 0x00000000_80000000 shifted so byte 3 = 0x80 -> d_wstrb=0xFF, d_addr=0x1000, resp_data=0xFFFFFFFF_FFFFFF80, resp_valid at N+3.
- Half store, wdata=0xBEEF, addr=0x2006 -> d_wstrb=0xC0, d_wdata[63:48]=0xBEEF, d_we=1. After ack: resp_valid=1, resp_data=0.
- Word load, addr=0x3002 -> no d_req_valid ever. Next cycle resp_valid=1, misaligned=1.
- d_req_ready held low 5 cycles, then response after 3 more cycles -> d_req_valid and d_addr stable throughout, stall continuous, single resp_valid pulse.
- Reset asserted while in WAIT -> immediate IDLE, req_ready=1. A subsequent d_rsp_valid produces no resp_valid.
- With CORE_LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, no bus response -> resp_valid with bus_err=1, 8 cycles after entering REQ.

Source files
------------

// File: rtl/core_lsu.sv
// Load/store unit between the EX/MEM stage and a valid/ready data bus: lane
// placement, strobes, load extension, misalignment flagging and pipeline stall.
// Optional watchdog: define CORE_LSU_TIMEOUT_EN to abort stalled bus transactions.
//
// state  | meaning
// IDLE   | ready for a request; latches request fields on req_valid
// REQ    | bus request held stable until d_req_ready
// WAIT   | request accepted by bus, waiting for d_rsp_valid
// RESP   | one-cycle completion pulse to the pipeline
module core_lsu #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [4:0]          req_regnum,
  output logic                stall,
  output logic                d_req_valid,
  input  logic                d_req_ready,
  output logic                d_we,
  output logic [ADDR_W-1:0]   d_addr,
  output logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W/8-1:0] d_wstrb,
  input  logic                d_rsp_valid,
  input  logic [DATA_W-1:0]   d_rdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic [4:0]          resp_regnum,
  output logic                misaligned,
  output logic                bus_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("core_lsu: DATA_W must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("core_lsu: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  logic                r_store;
  logic                r_signed;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [4:0]          r_regnum;
  logic                r_misal;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_misal_req;
  logic [OFF_W-1:0]    w_off;
  logic [OFF_W+2:0]    w_bit_off;
  logic [DATA_W-1:0]   w_shifted;
  logic [DATA_W-1:0]   w_mask;
  logic                w_sign;
  logic [DATA_W-1:0]   w_load;
  logic [STRB_W-1:0]   w_strb_base;
  logic                w_in_req;
  logic                w_in_resp;

  assign w_off     = r_addr[OFF_W-1:0];
  assign w_bit_off = {w_off, 3'b000};
  assign w_in_req  = (r_state == S_REQ);
  assign w_in_resp = (r_state == S_RESP);

  always_comb begin
    w_misal_req = 1'b0;
    case (req_size)
      2'd1:    w_misal_req = req_addr[0];
      2'd2:    w_misal_req = |req_addr[1:0];
      2'd3:    w_misal_req = (|req_addr[2:0]) || (DATA_W == 32);
      default: w_misal_req = 1'b0;
    endcase
  end

  // Load path: move the addressed lane down to bit 0, then mask and extend.
  assign w_shifted = d_rdata >> w_bit_off;

  always_comb begin
    w_mask      = '1;
    w_sign      = 1'b0;
    w_strb_base = '1;
    case (r_size)
      2'd0: begin
        w_mask      = DATA_W'(8'hFF);
        w_sign      = w_shifted[7];
        w_strb_base = STRB_W'(1);
      end
      2'd1: begin
        w_mask      = DATA_W'(16'hFFFF);
        w_sign      = w_shifted[15];
        w_strb_base = STRB_W'(3);
      end
      2'd2: begin
        w_mask      = DATA_W'(32'hFFFF_FFFF);
        w_sign      = w_shifted[31];
        w_strb_base = STRB_W'(15);
      end
      default: begin
        w_mask      = '1;
        w_sign      = 1'b0;
        w_strb_base = '1;
      end
    endcase
  end

  assign w_load = (w_shifted & w_mask) | ((r_signed && w_sign) ? ~w_mask : '0);

`ifdef CORE_LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;
  logic             w_expired;

  assign w_expired = (r_cnt >= CNT_LAST);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_store  <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= 2'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_regnum <= 5'd0;
      r_misal  <= 1'b0;
      r_rdata  <= '0;
`ifdef CORE_LSU_TIMEOUT_EN
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
`endif
    end else begin
`ifdef CORE_LSU_TIMEOUT_EN
      if (r_state == S_REQ || r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
`endif
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_store  <= req_store;
            r_signed <= req_signed;
            r_size   <= req_size;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_regnum <= req_regnum;
            r_misal  <= w_misal_req;
            r_rdata  <= '0;
            r_state  <= w_misal_req ? S_RESP : S_REQ;
`ifdef CORE_LSU_TIMEOUT_EN
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
`endif
          end
        end
        S_REQ: begin
          if (d_req_ready) begin
            r_state <= S_WAIT;
`ifdef CORE_LSU_TIMEOUT_EN
          end else if (w_expired) begin
            r_bus_err <= 1'b1;
            r_state   <= S_RESP;
`endif
          end
        end
        S_WAIT: begin
          if (d_rsp_valid) begin
            if (!r_store) r_rdata <= w_load;
            r_state <= S_RESP;
`ifdef CORE_LSU_TIMEOUT_EN
          end else if (w_expired) begin
            r_bus_err <= 1'b1;
            r_state   <= S_RESP;
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign stall       = (r_state != S_IDLE) || req_valid;

  assign d_req_valid = w_in_req;
  assign d_we        = w_in_req && r_store;
  assign d_addr      = w_in_req ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign d_wdata     = w_in_req ? (r_wdata << w_bit_off) : '0;
  assign d_wstrb     = !w_in_req ? '0 : (r_store ? (w_strb_base << w_off) : '1);

  assign resp_valid  = w_in_resp;
  assign resp_data   = w_in_resp ? r_rdata : '0;
  assign resp_regnum = r_regnum;
  assign misaligned  = w_in_resp && r_misal;

`ifdef CORE_LSU_TIMEOUT_EN
  assign bus_err = w_in_resp && r_bus_err;
`else
  assign bus_err = 1'b0;
`endif

endmodule
